// File: rtl/smi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smi_pkg
// Description : Shared SMI arbiter types: FSM state encoding, port index
//               constants and the round-robin next-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package smi_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arbState_t;

    localparam logic [1:0] c_PORT_A = 2'd0;
    localparam logic [1:0] c_PORT_B = 2'd1;
    localparam logic [1:0] c_PORT_C = 2'd2;
    localparam logic [1:0] c_PORT_D = 2'd3;

    // Next port in rotating order; wraps D back to A.
    function automatic logic [1:0] rrNext(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/smi_rr_select4.sv
`default_nettype none
// ============================================================================
// Module      : smi_rr_select4
// Description : Rotating-priority selector over 4 requests. The port after
//               the last owner has highest priority; the last owner itself
//               has lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
module smi_rr_select4
    import smi_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_lastOwner,
    output logic [1:0] o_winner,
    output logic       o_valid
);

    // Walk the four ports starting after the last owner; first request wins.
    always_comb begin : p_select
        logic [1:0] v_idx;
        o_winner = i_lastOwner;
        o_valid  = 1'b0;
        v_idx    = i_lastOwner;
        for (int i = 0; i < 4; i++) begin
            v_idx = rrNext(v_idx);
            if (!o_valid && i_req[v_idx]) begin
                o_winner = v_idx;
                o_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/smi_weighted_frame_arbiter_x4.sv
`default_nettype none
// ============================================================================
// Module      : smi_weighted_frame_arbiter_x4
// Description : Four-input frame-atomic SMI request arbiter. Each port may
//               keep ownership for up to its weight in consecutive frames,
//               after which ownership rotates round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module smi_weighted_frame_arbiter_x4
    import smi_pkg::*;
#(
    parameter int FlitWidth   = 4,
    parameter int WeightWidth = 4,
    parameter int DataWidth   = FlitWidth * 8
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiReqAInReady,
    input  logic [7:0]             smiReqAInEofc,
    input  logic [DataWidth-1:0]   smiReqAInData,
    output logic                   smiReqAInStop,
    input  logic                   smiReqBInReady,
    input  logic [7:0]             smiReqBInEofc,
    input  logic [DataWidth-1:0]   smiReqBInData,
    output logic                   smiReqBInStop,
    input  logic                   smiReqCInReady,
    input  logic [7:0]             smiReqCInEofc,
    input  logic [DataWidth-1:0]   smiReqCInData,
    output logic                   smiReqCInStop,
    input  logic                   smiReqDInReady,
    input  logic [7:0]             smiReqDInEofc,
    input  logic [DataWidth-1:0]   smiReqDInData,
    output logic                   smiReqDInStop,
    output logic                   smiReqOutReady,
    output logic [7:0]             smiReqOutEofc,
    output logic [DataWidth-1:0]   smiReqOutData,
    input  logic                   smiReqOutStop,
    input  logic [WeightWidth-1:0] weightA,
    input  logic [WeightWidth-1:0] weightB,
    input  logic [WeightWidth-1:0] weightC,
    input  logic [WeightWidth-1:0] weightD,
    output logic [1:0]             grantId,
    output logic                   grantValid
);

    logic [3:0]             w_req;
    logic [7:0]             w_eofc   [4];
    logic [DataWidth-1:0]   w_data   [4];
    logic [WeightWidth-1:0] w_weight [4];
    logic [3:0]             w_stop;

    arbState_t              r_state;
    arbState_t              w_stateNext;
    logic [1:0]             r_grantId;
    logic                   r_grantValid;
    logic [WeightWidth-1:0] r_credit [4];

    logic [1:0]             w_rrWinner;
    logic                   w_rrValid;
    logic                   w_keepOwner;
    logic [1:0]             w_winner;
    logic                   w_arbGo;
    logic                   w_xferLast;

    assign w_req = {smiReqDInReady, smiReqCInReady, smiReqBInReady, smiReqAInReady};

    assign w_eofc[c_PORT_A] = smiReqAInEofc;
    assign w_eofc[c_PORT_B] = smiReqBInEofc;
    assign w_eofc[c_PORT_C] = smiReqCInEofc;
    assign w_eofc[c_PORT_D] = smiReqDInEofc;

    assign w_data[c_PORT_A] = smiReqAInData;
    assign w_data[c_PORT_B] = smiReqBInData;
    assign w_data[c_PORT_C] = smiReqCInData;
    assign w_data[c_PORT_D] = smiReqDInData;

    assign w_weight[c_PORT_A] = weightA;
    assign w_weight[c_PORT_B] = weightB;
    assign w_weight[c_PORT_C] = weightC;
    assign w_weight[c_PORT_D] = weightD;

    smi_rr_select4 u_rrSelect (
        .i_req       (w_req),
        .i_lastOwner (r_grantId),
        .o_winner    (w_rrWinner),
        .o_valid     (w_rrValid)
    );

    // The previous owner keeps the grant while it still has quota left.
    assign w_keepOwner = w_req[r_grantId] && (r_credit[r_grantId] != '0);
    assign w_winner    = w_keepOwner ? r_grantId : w_rrWinner;
    assign w_arbGo     = (r_state == ST_IDLE) && w_rrValid;
    assign w_xferLast  = (r_state == ST_LOCKED) && w_req[r_grantId] &&
                         !smiReqOutStop && (w_eofc[r_grantId] != 8'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (!srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and the merged datapath; IDLE presents a quiet output.
    always_comb begin
        w_stateNext    = r_state;
        smiReqOutReady = 1'b0;
        smiReqOutEofc  = 8'd0;
        smiReqOutData  = '0;
        w_stop         = 4'b1111;
        case (r_state)
            ST_IDLE: begin
                if (w_arbGo) begin
                    w_stateNext = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                smiReqOutReady    = w_req[r_grantId];
                smiReqOutEofc     = w_eofc[r_grantId];
                smiReqOutData     = w_data[r_grantId];
                w_stop[r_grantId] = smiReqOutStop;
                if (w_xferLast) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Grant owner, frame-in-progress flag and per-port quota credits.
    always_ff @(posedge clk) begin
        if (!srst) begin
            r_grantId    <= c_PORT_D;
            r_grantValid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_credit[i] <= '0;
            end
        end else if (w_arbGo) begin
            r_grantId    <= w_winner;
            r_grantValid <= 1'b1;
            if (w_keepOwner) begin
                r_credit[r_grantId] <= r_credit[r_grantId] - WeightWidth'(1);
            end else if (w_weight[w_rrWinner] == '0) begin
                r_credit[w_rrWinner] <= '0;
            end else begin
                r_credit[w_rrWinner] <= w_weight[w_rrWinner] - WeightWidth'(1);
            end
        end else if (w_xferLast) begin
            r_grantValid <= 1'b0;
        end
    end

    assign smiReqAInStop = w_stop[c_PORT_A];
    assign smiReqBInStop = w_stop[c_PORT_B];
    assign smiReqCInStop = w_stop[c_PORT_C];
    assign smiReqDInStop = w_stop[c_PORT_D];
    assign grantId       = r_grantId;
    assign grantValid    = r_grantValid;

endmodule
`default_nettype wire

// File: tb/tb_smi_weighted_frame_arbiter_x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_smi_weighted_frame_arbiter_x4
// Description : Directed self-checking bench for the weighted frame arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smi_weighted_frame_arbiter_x4;

    localparam int c_DW = 32;

    logic            clk = 1'b0;
    logic            srst = 1'b0;
    logic [3:0]      rdy;
    logic [7:0]      eofc [4];
    logic [c_DW-1:0] dat  [4];
    logic [3:0]      wt   [4];
    logic            outStop;

    wire             outReady;
    wire [7:0]       outEofc;
    wire [c_DW-1:0]  outData;
    wire [1:0]       gId;
    wire             gVal;
    wire             stA, stB, stC, stD;
    wire [3:0]       w_stops;

    int total = 0;
    int bad   = 0;

    assign w_stops = {stD, stC, stB, stA};

    always #5 clk = ~clk;

    smi_weighted_frame_arbiter_x4 dut (
        .clk            (clk),
        .srst           (srst),
        .smiReqAInReady (rdy[0]), .smiReqAInEofc (eofc[0]), .smiReqAInData (dat[0]), .smiReqAInStop (stA),
        .smiReqBInReady (rdy[1]), .smiReqBInEofc (eofc[1]), .smiReqBInData (dat[1]), .smiReqBInStop (stB),
        .smiReqCInReady (rdy[2]), .smiReqCInEofc (eofc[2]), .smiReqCInData (dat[2]), .smiReqCInStop (stC),
        .smiReqDInReady (rdy[3]), .smiReqDInEofc (eofc[3]), .smiReqDInData (dat[3]), .smiReqDInStop (stD),
        .smiReqOutReady (outReady),
        .smiReqOutEofc  (outEofc),
        .smiReqOutData  (outData),
        .smiReqOutStop  (outStop),
        .weightA        (wt[0]),
        .weightB        (wt[1]),
        .weightC        (wt[2]),
        .weightD        (wt[3]),
        .grantId        (gId),
        .grantValid     (gVal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setP(input int p, input logic r, input logic [7:0] e, input logic [c_DW-1:0] d);
        rdy[p]  = r;
        eofc[p] = e;
        dat[p]  = d;
    endtask

    task automatic idleInputs;
        for (int p = 0; p < 4; p++) setP(p, 1'b0, 8'd0, '0);
        outStop = 1'b0;
    endtask

    task automatic doReset;
        idleInputs();
        srst = 1'b0;
        tick();
        tick();
        srst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        int stall;
        int guard;
        logic [1:0] expW [8];

        idleInputs();
        for (int p = 0; p < 4; p++) wt[p] = 4'd1;
        @(negedge clk);
        tick();
        #1;
        chk("rst grantValid", gVal, 0);
        chk("rst grantId", gId, 3);
        chk("rst outReady", outReady, 0);
        chk("rst outEofc", outEofc, 0);
        chk("rst outData", outData, 0);
        chk("rst stops", w_stops, 4'b1111);
        srst = 1'b1;
        tick();

        // Single port, 3-flit frame from A.
        setP(0, 1'b1, 8'd0, 32'hA0);
        #1;
        chk("single arb outReady", outReady, 0);
        chk("single arb stopA", stA, 1);
        tick(); #1;
        chk("single grantId", gId, 0);
        chk("single grantValid", gVal, 1);
        chk("single f0 ready", outReady, 1);
        chk("single f0 data", outData, 32'hA0);
        chk("single f0 eofc", outEofc, 0);
        chk("single stops", w_stops, 4'b1110);
        tick();
        setP(0, 1'b1, 8'd0, 32'hA1); #1;
        chk("single f1 data", outData, 32'hA1);
        tick();
        setP(0, 1'b1, 8'd4, 32'hA2); #1;
        chk("single f2 data", outData, 32'hA2);
        chk("single f2 eofc", outEofc, 4);
        tick();
        setP(0, 1'b0, 8'd0, '0); #1;
        chk("single end grantValid", gVal, 0);
        chk("single end grantId", gId, 0);
        chk("single end outReady", outReady, 0);
        chk("single end stops", w_stops, 4'b1111);

        // Fairness: equal weights, everyone sends 1-flit frames.
        doReset();
        for (int p = 0; p < 4; p++) setP(p, 1'b1, 8'd1, 32'hB0 + p);
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            chk($sformatf("fair c%0d outReady", cyc), outReady, cyc % 2);
            if (cyc % 2 == 1) begin
                chk($sformatf("fair c%0d grantId", cyc), gId, (cyc / 2) % 4);
                chk($sformatf("fair c%0d data", cyc), outData, 32'hB0 + (cyc / 2) % 4);
            end
            tick();
        end

        // Weighting: A=3, B=1.
        doReset();
        wt[0] = 4'd3;
        expW = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
        setP(0, 1'b1, 8'd1, 32'hC0);
        setP(1, 1'b1, 8'd1, 32'hC1);
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (cyc % 2 == 1) begin
                chk($sformatf("weight frame%0d grantId", cyc / 2), gId, expW[cyc / 2]);
                chk($sformatf("weight frame%0d ready", cyc / 2), outReady, 1);
            end
            tick();
        end
        wt[0] = 4'd1;

        // Atomicity: 5-flit A frame with a 10-cycle stall, B waiting.
        doReset();
        setP(1, 1'b1, 8'd1, 32'hB0);
        setP(0, 1'b1, 8'd0, 32'hA0);
        #1;
        chk("atom arb stopB", stB, 1);
        tick();
        f = 0; stall = 10; guard = 0;
        while (f < 5 && guard < 40) begin
            setP(0, 1'b1, (f == 4) ? 8'd1 : 8'd0, 32'hA0 + f);
            outStop = (f == 2 && stall > 0);
            #1;
            chk($sformatf("atom g%0d ready", guard), outReady, 1);
            chk($sformatf("atom g%0d data", guard), outData, 32'hA0 + f);
            chk($sformatf("atom g%0d grantId", guard), gId, 0);
            chk($sformatf("atom g%0d stopB", guard), stB, 1);
            chk($sformatf("atom g%0d stopA", guard), stA, outStop);
            @(posedge clk);
            if (outStop) stall--; else f++;
            @(negedge clk);
            guard++;
        end
        chk("atom flits done", f, 5);
        chk("atom stall used", stall, 0);
        outStop = 1'b0;
        setP(0, 1'b0, 8'd0, '0);
        #1;
        chk("atom gap outReady", outReady, 0);
        chk("atom gap stopB", stB, 1);
        tick(); #1;
        chk("atom B grantId", gId, 1);
        chk("atom B data", outData, 32'hB0);

        // Weight 0 on C: one frame per turn alternating with D.
        doReset();
        wt[2] = 4'd0;
        setP(2, 1'b1, 8'd1, 32'hE2);
        setP(3, 1'b1, 8'd1, 32'hE3);
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (cyc % 2 == 1)
                chk($sformatf("w0 frame%0d grantId", cyc / 2), gId, ((cyc / 2) % 2 == 0) ? 2 : 3);
            tick();
        end
        wt[2] = 4'd1;

        // Owner drops Ready mid-frame.
        doReset();
        setP(0, 1'b1, 8'd0, 32'hA0);
        setP(1, 1'b1, 8'd1, 32'hB0);
        tick(); #1;
        chk("drop f0 ready", outReady, 1);
        tick();
        setP(0, 1'b0, 8'd0, 32'hA1); #1;
        chk("drop outReady", outReady, 0);
        chk("drop grantValid", gVal, 1);
        chk("drop grantId", gId, 0);
        chk("drop stopB", stB, 1);
        tick();
        setP(0, 1'b1, 8'd1, 32'hA1); #1;
        chk("drop resume ready", outReady, 1);
        chk("drop resume data", outData, 32'hA1);
        tick();
        setP(0, 1'b0, 8'd0, '0); #1;
        chk("drop end grantValid", gVal, 0);

        // Reset mid-frame after 2 of 4 flits.
        doReset();
        setP(0, 1'b1, 8'd0, 32'hC0);
        tick();
        tick();
        setP(0, 1'b1, 8'd0, 32'hC1);
        tick();
        setP(0, 1'b1, 8'd0, 32'hC2);
        srst = 1'b0;
        tick(); #1;
        chk("mrst outReady", outReady, 0);
        chk("mrst stops", w_stops, 4'b1111);
        chk("mrst grantValid", gVal, 0);
        srst = 1'b1;
        setP(0, 1'b1, 8'd1, 32'hD0);
        setP(1, 1'b1, 8'd1, 32'hD1);
        #1;
        chk("mrst arb outReady", outReady, 0);
        tick(); #1;
        chk("mrst restart grantId", gId, 0);
        chk("mrst restart data", outData, 32'hD0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
